// File: rtl/rv32i_pkg.sv
// rv32i shared types, opcodes and decode helpers
// for the issue controller and its scoreboard
package rv32i_pkg;

  localparam int NREGS = 32;

  typedef logic [31:0] rv32_inst_t;

  typedef enum logic [1:0] {
    UNIT_ALU    = 2'd0,
    UNIT_MEM    = 2'd1,
    UNIT_BRANCH = 2'd2,
    UNIT_SYS    = 2'd3
  } rv32i_unit_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_STALL,
    ST_VALID
  } issue_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
    logic       decode_error;
  } rv32_fields_t;

  typedef struct packed {
    logic        rs1;
    logic        rs2;
    logic        rd;
    logic        drain;
    rv32i_unit_t unit;
  } rv32_usage_t;

  function automatic logic rv32_is_known(input logic [6:0] op);
    return op inside {OPC_OP, OPC_IMM, OPC_LOAD, OPC_STORE,
                      OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI,
                      OPC_AUIPC, OPC_SYSTEM, OPC_FENCE};
  endfunction

  function automatic rv32_usage_t rv32_get_usage(
    input logic [6:0] op,
    input logic [2:0] f3
  );
    rv32_usage_t u;
    u = '{1'b0, 1'b0, 1'b0, 1'b0, UNIT_SYS};
    unique case (1'b1)
      op == OPC_OP:     u = '{1'b1, 1'b1, 1'b1, 1'b0, UNIT_ALU};
      op == OPC_IMM:    u = '{1'b1, 1'b0, 1'b1, 1'b0, UNIT_ALU};
      op == OPC_LUI,
      op == OPC_AUIPC:  u = '{1'b0, 1'b0, 1'b1, 1'b0, UNIT_ALU};
      op == OPC_LOAD:   u = '{1'b1, 1'b0, 1'b1, 1'b0, UNIT_MEM};
      op == OPC_STORE:  u = '{1'b1, 1'b1, 1'b0, 1'b0, UNIT_MEM};
      op == OPC_JAL:    u = '{1'b0, 1'b0, 1'b1, 1'b0, UNIT_BRANCH};
      op == OPC_JALR:   u = '{1'b1, 1'b0, 1'b1, 1'b0, UNIT_BRANCH};
      op == OPC_BRANCH: u = '{1'b1, 1'b1, 1'b0, 1'b0, UNIT_BRANCH};
      op == OPC_SYSTEM: u = '{!f3[2] && (f3[1:0] != 2'b00), 1'b0,
                              f3[1:0] != 2'b00, 1'b1, UNIT_SYS};
      op == OPC_FENCE:  u = '{1'b0, 1'b0, 1'b0, 1'b1, UNIT_SYS};
      default: ;
    endcase
    return u;
  endfunction

  function automatic rv32_fields_t rv32_get_fields(input rv32_inst_t i);
    rv32_fields_t f;
    f.funct7       = i[31:25];
    f.rs2          = i[24:20];
    f.rs1          = i[19:15];
    f.funct3       = i[14:12];
    f.rd           = i[11:7];
    f.opcode       = i[6:0];
    f.decode_error = !rv32_is_known(i[6:0]);
    return f;
  endfunction

endpackage

// File: rtl/rv32i_scoreboard.sv
// rv32i register scoreboard: outstanding-write bits
// issue set beats writeback clear; sticky wb_error
module rv32i_scoreboard
  import rv32i_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [4:0]       set_rd,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic [NREGS-1:0] busy,
  output logic             wb_error
);

  logic [NREGS-1:0] busy_nxt;
  logic             wb_bad;
  logic             wb_hit;

  // next busy vector: clear first, then set so the set wins
  always_comb begin
    busy_nxt = busy;
    wb_hit   = set_en && (set_rd == wb_rd);
    wb_bad   = wb_valid &&
               ((wb_rd == 5'd0) || (!busy[wb_rd] && !wb_hit));
    if (wb_valid && !wb_bad) busy_nxt[wb_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // scoreboard state and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      wb_error <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (wb_bad) wb_error <= 1'b1;
    end
  end

endmodule

// File: rtl/rv32i_issue_controller.sv
// rv32i single-entry issue stage with hazard screen
// holds one instruction until its operands are clear
module rv32i_issue_controller
  import rv32i_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_valid,
  output logic         inst_ready,
  input  logic [31:0]  inst_data,
  output logic         issue_valid,
  input  logic         issue_ready,
  output rv32_fields_t issue_fields,
  output rv32i_unit_t  issue_unit,
  input  logic         wb_valid,
  input  logic [4:0]   wb_rd,
  input  logic         flush,
  output logic [31:0]  busy,
  output logic         wb_error
);

  issue_state_t state;
  issue_state_t state_nxt;
  rv32_usage_t  use_q;
  logic         hazard;
  logic         accept;
  logic         fire;
  logic         set_en;

  assign issue_unit = use_q.unit;

  // hazard screen against registered busy, plus handshakes
  always_comb begin
    hazard = (use_q.rs1 && busy[issue_fields.rs1]) ||
             (use_q.rs2 && busy[issue_fields.rs2]) ||
             (use_q.rd && busy[issue_fields.rd]) ||
             (use_q.drain && (busy != '0));
    issue_valid = (state == ST_VALID) ||
                  ((state == ST_STALL) && !hazard);
    inst_ready = !rst && !flush &&
                 ((state == ST_EMPTY) ||
                  (issue_valid && issue_ready));
    accept = inst_ready && inst_valid;
    fire   = issue_valid && issue_ready && !flush;
    set_en = fire && use_q.rd && (issue_fields.rd != 5'd0);
  end

  // next state: flush, then accept, then issue, then unstall
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = ST_EMPTY;
    else if (accept) state_nxt = ST_STALL;
    else if (fire) state_nxt = ST_EMPTY;
    else if ((state == ST_STALL) && !hazard) state_nxt = ST_VALID;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else state <= state_nxt;
  end

  // holding register loads only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_fields <= '0;
      use_q        <= '0;
    end else if (accept) begin
      issue_fields <= rv32_get_fields(inst_data);
      use_q <= rv32_get_usage(inst_data[6:0], inst_data[14:12]);
    end
  end

  rv32i_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_rd   (issue_fields.rd),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .busy     (busy),
    .wb_error (wb_error)
  );

endmodule

// File: tb/tb_rv32i_issue_controller.sv
// rv32i issue controller bench
// directed scenarios plus random run against a model
module tb_rv32i_issue_controller;
  import rv32i_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst_data;
  logic         issue_valid;
  logic         issue_ready;
  rv32_fields_t issue_fields;
  rv32i_unit_t  issue_unit;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic         flush;
  logic [31:0]  busy;
  logic         wb_error;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv32i_issue_controller dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_data    (inst_data),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_fields (issue_fields),
    .issue_unit   (issue_unit),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .busy         (busy),
    .wb_error     (wb_error)
  );

  function automatic logic [31:0] enc(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] d,
                       input logic ir, input logic wv,
                       input logic [4:0] wr, input logic fl);
    inst_valid = iv; inst_data = d; issue_ready = ir;
    wb_valid = wv; wb_rd = wr; flush = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset;
    idle; rst = 1'b1; tick; rst = 1'b0; #1;
  endtask

  // reference operand usage, from the opcode table
  function automatic void ref_use(input logic [31:0] in,
    output bit u1, output bit u2, output bit ud, output bit dr,
    output logic [1:0] un, output bit er);
    logic [6:0] op; logic [2:0] f3;
    op = in[6:0]; f3 = in[14:12];
    u1 = 0; u2 = 0; ud = 0; dr = 0; er = 0; un = 2'd3;
    case (op)
      7'b0110011: begin u1 = 1; u2 = 1; ud = 1; un = 2'd0; end
      7'b0010011: begin u1 = 1; ud = 1; un = 2'd0; end
      7'b0110111, 7'b0010111: begin ud = 1; un = 2'd0; end
      7'b0000011: begin u1 = 1; ud = 1; un = 2'd1; end
      7'b0100011: begin u1 = 1; u2 = 1; un = 2'd1; end
      7'b1101111: begin ud = 1; un = 2'd2; end
      7'b1100111: begin u1 = 1; ud = 1; un = 2'd2; end
      7'b1100011: begin u1 = 1; u2 = 1; un = 2'd2; end
      7'b1110011: begin
        dr = 1;
        if (f3 inside {3'd1, 3'd2, 3'd3}) begin u1 = 1; ud = 1; end
        else if (f3 inside {3'd5, 3'd6, 3'd7}) ud = 1;
      end
      7'b0001111: dr = 1;
      default: er = 1;
    endcase
  endfunction

  task automatic test_reset;
    idle; rst = 1'b1; #1;
    n_chk++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iv: got %b want 0", issue_valid); end
    n_chk++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
    n_chk++; if (wb_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", wb_error); end
    n_chk++; if (issue_fields !== '0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", issue_fields); end
    n_chk++; if (issue_unit !== UNIT_ALU) begin n_fail++; $display("FAIL reset_unit: got %0d want 0", issue_unit); end
    tick; tick;
    n_chk++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_in_rst: got %b want 0", inst_ready); end
    rst = 1'b0; #1;
    n_chk++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_after: got %b want 1", inst_ready); end
  endtask

  task automatic test_rs1_hazard;
    logic [31:0] addi5, add6;
    addi5 = enc(7'd0, 5'd1, 5'd0, 3'd0, 5'd5, 7'b0010011);
    add6  = enc(7'd0, 5'd5, 5'd5, 3'd0, 5'd6, 7'b0110011);
    do_reset;
    drive(1'b1, addi5, 1'b0, 1'b0, 5'd0, 1'b0);
    n_chk++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL raw_accept: rdy=%b want 1", inst_ready); end
    tick;
    drive(1'b1, add6, 1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (issue_valid !== 1'b1 || issue_fields.rd !== 5'd5) begin n_fail++; $display("FAIL raw_addi_issue: iv=%b rd=%0d want 1,5", issue_valid, issue_fields.rd); end
    n_chk++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL raw_b2b_rdy: got %b want 1", inst_ready); end
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (issue_valid !== 1'b0 || busy !== 32'h20) begin n_fail++; $display("FAIL raw_stall: iv=%b busy=%h want 0,20", issue_valid, busy); end
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 1'b0);
    n_chk++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass: iv=%b want 0", issue_valid); end
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (issue_valid !== 1'b1 || issue_fields.rd !== 5'd6 || busy !== 32'h0) begin n_fail++; $display("FAIL raw_release: iv=%b rd=%0d busy=%h want 1,6,0", issue_valid, issue_fields.rd, busy); end
    tick;
    idle;
    n_chk++; if (busy !== 32'h40 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL raw_set6: busy=%h iv=%b want 40,0", busy, issue_valid); end
  endtask

  task automatic test_waw;
    logic [31:0] lui7;
    lui7 = enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd7, 7'b0110111);
    do_reset;
    drive(1'b1, lui7, 1'b0, 1'b0, 5'd0, 1'b0); tick;
    drive(1'b1, lui7, 1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL waw_first: iv=%b want 1", issue_valid); end
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
      n_chk++; if (issue_valid !== 1'b0 || busy !== 32'h80) begin n_fail++; $display("FAIL waw_stall: iv=%b busy=%h want 0,80", issue_valid, busy); end
      tick;
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 5'd7, 1'b0); tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (issue_valid !== 1'b1 || busy !== 32'h0) begin n_fail++; $display("FAIL waw_release: iv=%b busy=%h want 1,0", issue_valid, busy); end
    tick; idle;
    n_chk++; if (busy !== 32'h80) begin n_fail++; $display("FAIL waw_reset7: busy=%h want 80", busy); end
  endtask

  task automatic test_same_cycle;
    logic [31:0] lui3;
    lui3 = enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd3, 7'b0110111);
    do_reset;
    drive(1'b1, lui3, 1'b0, 1'b0, 5'd0, 1'b0); tick;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 5'd3, 1'b0);
    n_chk++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL same_iv: iv=%b want 1", issue_valid); end
    tick; idle;
    n_chk++; if (busy !== 32'h8 || wb_error !== 1'b0) begin n_fail++; $display("FAIL same_setwins: busy=%h err=%b want 8,0", busy, wb_error); end
  endtask

  task automatic test_backpressure_flush;
    logic [31:0] lui1, sw, addi4;
    lui1  = enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'b0110111);
    sw    = enc(7'd0, 5'd2, 5'd3, 3'd2, 5'd0, 7'b0100011);
    addi4 = enc(7'd0, 5'd3, 5'd0, 3'd0, 5'd4, 7'b0010011);
    do_reset;
    drive(1'b1, lui1, 1'b0, 1'b0, 5'd0, 1'b0); tick;
    drive(1'b1, sw, 1'b1, 1'b0, 5'd0, 1'b0); tick;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, addi4, 1'b0, 1'b0, 5'd0, 1'b0);
      n_chk++; if (issue_valid !== 1'b1 || inst_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold: iv=%b rdy=%b want 1,0", issue_valid, inst_ready); end
      n_chk++; if (issue_fields.opcode !== 7'b0100011 || issue_fields.rs1 !== 5'd3 || issue_fields.rs2 !== 5'd2 || issue_fields.funct3 !== 3'd2 || issue_unit !== UNIT_MEM) begin n_fail++; $display("FAIL bp_fields: f=%h unit=%0d want sw x2,0(x3) MEM", issue_fields, issue_unit); end
      tick;
    end
    drive(1'b1, addi4, 1'b1, 1'b0, 5'd0, 1'b1);
    n_chk++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL flush_rdy: rdy=%b want 0", inst_ready); end
    tick;
    drive(1'b1, addi4, 1'b0, 1'b0, 5'd0, 1'b0);
    n_chk++; if (issue_valid !== 1'b0 || busy !== 32'h2 || inst_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty: iv=%b busy=%h rdy=%b want 0,2,1", issue_valid, busy, inst_ready); end
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (issue_valid !== 1'b1 || issue_fields.rd !== 5'd4) begin n_fail++; $display("FAIL flush_next: iv=%b rd=%0d want 1,4", issue_valid, issue_fields.rd); end
    tick; idle;
    n_chk++; if (busy !== 32'h12) begin n_fail++; $display("FAIL flush_busy: busy=%h want 12", busy); end
  endtask

  task automatic test_drain;
    logic [31:0] lui5, csr;
    lui5 = enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd5, 7'b0110111);
    csr  = enc(7'h18, 5'd0, 5'd2, 3'd1, 5'd1, 7'b1110011);
    do_reset;
    drive(1'b1, lui5, 1'b0, 1'b0, 5'd0, 1'b0); tick;
    drive(1'b1, csr, 1'b1, 1'b0, 5'd0, 1'b0); tick;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
      n_chk++; if (issue_valid !== 1'b0 || busy !== 32'h20) begin n_fail++; $display("FAIL drain_stall: iv=%b busy=%h want 0,20", issue_valid, busy); end
      tick;
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 1'b0); tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (issue_valid !== 1'b1 || issue_unit !== UNIT_SYS) begin n_fail++; $display("FAIL drain_issue: iv=%b unit=%0d want 1,3", issue_valid, issue_unit); end
    tick; idle;
    n_chk++; if (busy !== 32'h2) begin n_fail++; $display("FAIL drain_busy: busy=%h want 2", busy); end
  endtask

  task automatic test_error_reset;
    logic [31:0] lui5, add6;
    lui5 = enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd5, 7'b0110111);
    add6 = enc(7'd0, 5'd5, 5'd5, 3'd0, 5'd6, 7'b0110011);
    do_reset;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 5'd9, 1'b0); tick; idle;
    n_chk++; if (wb_error !== 1'b1 || busy !== 32'h0) begin n_fail++; $display("FAIL err_set: err=%b busy=%h want 1,0", wb_error, busy); end
    drive(1'b1, lui5, 1'b0, 1'b0, 5'd0, 1'b0); tick;
    drive(1'b1, add6, 1'b1, 1'b0, 5'd0, 1'b0); tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (issue_valid !== 1'b0 || busy !== 32'h20) begin n_fail++; $display("FAIL err_stall: iv=%b busy=%h want 0,20", issue_valid, busy); end
    #2; rst = 1'b1; #1;
    n_chk++; if (busy !== 32'h0 || wb_error !== 1'b0 || issue_valid !== 1'b0 || inst_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst: busy=%h err=%b iv=%b rdy=%b want 0,0,0,0", busy, wb_error, issue_valid, inst_ready); end
    tick; rst = 1'b0; #1;
    n_chk++; if (inst_ready !== 1'b1 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dropped: rdy=%b iv=%b want 1,0", inst_ready, issue_valid); end
  endtask

  task automatic test_random;
    logic [6:0] ops [12];
    logic [31:0] minst, mbusy, d;
    bit mheld, merr, u1, u2, ud, dr, er, hz, eiv, erdy, fire, acc;
    logic [1:0] un;
    logic iv, ir, wv, fl;
    logic [4:0] wr;
    logic [4:0] rs1, rs2, rd;
    rv32_fields_t ef;
    int q [$];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b1110011, 7'b0001111, 7'b1111111};
    do_reset;
    mheld = 0; merr = 0; mbusy = 32'h0; minst = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      d = $urandom;
      d[6:0] = ops[$urandom_range(0, 11)];
      if (d[6:0] == 7'b1110011 && d[14:12] == 3'd4) d[14:12] = 3'd1;
      d[11:7] = 5'($urandom_range(0, 7));
      d[19:15] = 5'($urandom_range(0, 7));
      d[24:20] = 5'($urandom_range(0, 7));
      iv = 1'($urandom_range(0, 1));
      ir = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      wv = ($urandom_range(0, 9) < 3);
      q.delete();
      for (int r = 1; r < 32; r++) if (mbusy[r]) q.push_back(r);
      if (q.size() != 0 && $urandom_range(0, 9) != 0)
        wr = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        wr = 5'($urandom_range(0, 7));
      drive(iv, d, ir, wv, wr, fl);
      ref_use(minst, u1, u2, ud, dr, un, er);
      rs1 = minst[19:15]; rs2 = minst[24:20]; rd = minst[11:7];
      hz = (u1 && rs1 != 0 && mbusy[rs1]) ||
           (u2 && rs2 != 0 && mbusy[rs2]) ||
           (ud && rd != 0 && mbusy[rd]) ||
           (dr && mbusy != 0);
      eiv = mheld && !hz;
      erdy = !fl && (!mheld || (eiv && ir));
      n_chk++; if (issue_valid !== eiv) begin n_fail++; $display("FAIL rnd_iv c%0d: got %b want %b", c, issue_valid, eiv); end
      n_chk++; if (inst_ready !== erdy) begin n_fail++; $display("FAIL rnd_rdy c%0d: got %b want %b", c, inst_ready, erdy); end
      n_chk++; if (busy !== mbusy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h want %h", c, busy, mbusy); end
      n_chk++; if (wb_error !== merr) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, wb_error, merr); end
      if (eiv) begin
        ef.funct7 = minst[31:25]; ef.rs2 = rs2; ef.rs1 = rs1;
        ef.funct3 = minst[14:12]; ef.rd = rd; ef.opcode = minst[6:0];
        ef.decode_error = er;
        n_chk++; if (issue_fields !== ef || issue_unit !== un) begin n_fail++; $display("FAIL rnd_fields c%0d: got %h/%0d want %h/%0d", c, issue_fields, issue_unit, ef, un); end
      end
      fire = eiv && ir && !fl;
      acc = erdy && iv;
      if (wv) begin
        if (wr == 0 || (!mbusy[wr] && !(fire && ud && rd == wr)))
          merr = 1;
        else
          mbusy[wr] = 1'b0;
      end
      if (fire && ud && rd != 0) mbusy[rd] = 1'b1;
      if (fl) mheld = 0;
      else if (acc) begin mheld = 1; minst = d; end
      else if (fire) mheld = 0;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_rs1_hazard;
    test_waw;
    test_same_cycle;
    test_backpressure_flush;
    test_drain;
    test_error_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rv32i_issue_controller.md
RV32I_ISSUE_CONTROLLER -- requirements
Module: rv32i_issue_controller

Interface
REQ-001 SHALL have no parameters; the register count of 32 is fixed by RV32I.
REQ-002 SHALL use one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-003 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  asynchronous active-high reset.
REQ-005 Port: inst_valid  in  1  fetched instruction present.
REQ-006 Port: inst_ready  out  1  controller accepts the instruction this cycle.
REQ-007 Port: inst_data  in  32  raw rv32_inst_t.
REQ-008 Port: issue_valid  out  1  held instruction is hazard-free and offered downstream.
REQ-009 Port: issue_ready  in  1  downstream accepts.
REQ-010 Port: issue_fields  out  rv32_fields_t  decoded fields, produced by rv32_get_fields.
REQ-011 Port: issue_unit  out  2  rv32i_unit_t: ALU=0, MEM=1, BRANCH=2, SYS=3.
REQ-012 Port: wb_valid  in  1  a writeback retires the destination register.
REQ-013 Port: wb_rd  in  5  retired register index.
REQ-014 Port: flush  in  1  discard the held instruction.
REQ-015 Port: busy  out  32  scoreboard; bit i set means a write to xi is outstanding.
REQ-016 Port: wb_error  out  1  sticky; set on writeback to a non-busy register.

Function
REQ-017 One-entry holding register; FSM states are EMPTY, STALL (held, hazard present) and VALID (held, issue_valid=1).
REQ-018 inst_ready=1 when flush=0 and the state is EMPTY, or VALID with issue_ready=1; no combinational path from inst_valid to inst_ready.
REQ-019 Latency: an instruction accepted in cycle N SHALL give issue_valid no earlier than N+1.
REQ-020 Operand usage by opcode:
- OP: rs1, rs2 and rd.
- IMM, LOAD, JALR: rs1 and rd.
- STORE, BRANCH: rs1 and rs2; no rd.
- LUI, AUIPC, JAL: rd only.
- SYSTEM CSRRW/S/C: rs1 and rd.
- SYSTEM CSRRWI/SI/CI: rd only.
- SYSTEM ENV, FENCE: none.
REQ-021 Unit mapping: OP/IMM/LUI/AUIPC -> ALU; LOAD/STORE -> MEM; JAL/JALR/BRANCH -> BRANCH; SYSTEM/FENCE -> SYS.
REQ-022 Unknown opcode: issue_unit=SYS, issue_fields.decode_error=1, no operands and no rd.
REQ-023 Hazard exists when any used rs1, rs2 or rd (WAW) has its busy bit set.
REQ-024 SYSTEM and FENCE SHALL additionally stall until busy==0 (drain).
REQ-025 Register x0 is never busy and never causes a hazard.
REQ-026 Hazard evaluation uses registered busy only (no same-cycle bypass).
- A writeback in cycle N clears the hazard, and the instruction issues at N+1.
REQ-027 When issue_valid and issue_ready are both 1 and rd is used and nonzero, busy[rd] SHALL set the next cycle.
REQ-028 wb_valid clears busy[wb_rd] the next cycle.
- If the same register is set by issue and cleared by wb in one cycle, the set SHALL win.
REQ-029 wb_valid with wb_rd=0, or to a clear busy bit, SHALL leave busy unchanged and set wb_error.
REQ-030 flush SHALL move the FSM to EMPTY next cycle with issue_valid=0.
- busy is unchanged by flush, because outstanding writes still retire.
- flush has priority over both issue and accept in the same cycle.
REQ-031 issue_fields and issue_unit SHALL be stable while issue_valid=1 and issue_ready=0.
- VALID SHALL NOT revert to STALL, since busy only clears while VALID.

Reset
REQ-032 rst asserted SHALL asynchronously force these values:
- state=EMPTY, issue_valid=0, busy=0, wb_error=0, issue_fields=0, issue_unit=ALU.
REQ-033 Reset mid-operation SHALL drop the held instruction.
REQ-034 inst_ready SHALL be 0 while rst=1 and equal 1 in the first cycle after deassertion.

Structure
REQ-035 rv32i_unit_t and the operand-usage function SHALL reside in the shared rv32i package.
REQ-036 The scoreboard (busy vector, set/clear priority, wb_error) SHALL be a sub-module named rv32i_scoreboard.

Verification
REQ-037 Hazard on rs1: issue addi x5,x0,1, then add x6,x5,x5 with no wb.
- Required: add stalls with issue_valid=0.
- wb_rd=5 at cycle N -> add issues at N+1, and busy[6] sets.
REQ-038 WAW: lui x7 issued, then a second lui x7 presented.
- Required: stall until wb_rd=7, with busy=0x80 meanwhile.
REQ-039 Same-cycle set/clear: issue to x3 and wb_rd=3 in one cycle.
- Required: busy[3]=1 afterward, wb_error=0.
REQ-040 Backpressure and flush: held sw with issue_ready=0 for 3 cycles.
- Required: fields stable across the 3 cycles.
- flush -> EMPTY, busy unchanged, next instruction accepted one cycle later.
REQ-041 Drain: csrrw while busy=0x0000_0020 -> stall until wb_rd=5, then issue_unit=SYS.
REQ-042 Error and reset:
- wb_rd=9 with busy[9]=0 -> wb_error=1.
- rst pulse mid-stall -> busy=0, wb_error=0, issue_valid=0 asynchronously.
